pipe_stage_elastic: RTL and testbench



---
 rtl/pipe_stage_elastic_pkg.sv | 27 ++
 rtl/pipe_stage_elastic_slot.sv | 101 ++++++++++
 rtl/pipe_stage_elastic.sv | 78 +++++++
 tb/tb_pipe_stage_elastic.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_elastic_pkg.sv
// Shared helpers for the elastic pipeline: occupancy counter width, slot
// transfer decode, and the flush merge that keeps selected payload bits.
package pipe_pkg;

   // Widest payload the flush merge can handle; DATA_W must not exceed it.
   localparam int MERGE_MAX_W = 256;

   typedef logic [MERGE_MAX_W-1:0] merge_word_t;

   typedef enum logic [1:0] {
      SLOT_FLUSH,
      SLOT_UNSKID,
      SLOT_LOAD,
      SLOT_STALL
   } slot_op_e;

   function automatic int occ_width(input int depth);
      return $clog2(2 * depth + 1);
   endfunction

   function automatic merge_word_t flush_merge(input merge_word_t d,
                                               input merge_word_t keep,
                                               input merge_word_t bubble);
      return (d & keep) | (bubble & ~keep);
   endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One elastic slot: a main register plus a one-entry skid register, so the
// upstream ready is a flop output and never a path from downstream ready.
module elastic_slot
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 16,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter logic [DATA_W-1:0] KEEP_MASK  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o
);

   localparam merge_word_t KEEP_W   = merge_word_t'(KEEP_MASK);
   localparam merge_word_t BUBBLE_W = merge_word_t'(BUBBLE_VAL);

   logic              main_v_q, main_v_d;
   logic              skid_v_q, skid_v_d;
   logic [DATA_W-1:0] main_dat_q, main_dat_d;
   logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
   logic [DATA_W-1:0] main_flush, skid_flush;
   logic              acc, pop;
   slot_op_e          op;

   assign acc = in_valid_i & ~skid_v_q;
   assign pop = main_v_q & out_ready_i;

   always_comb begin
      main_flush = DATA_W'(flush_merge(merge_word_t'(main_dat_q), KEEP_W, BUBBLE_W));
      skid_flush = DATA_W'(flush_merge(merge_word_t'(skid_dat_q), KEEP_W, BUBBLE_W));
   end

   always_comb begin
      op = SLOT_STALL;
      if (flush_i) begin
         op = SLOT_FLUSH;
      end else if (~main_v_q | pop) begin
         op = skid_v_q ? SLOT_UNSKID : SLOT_LOAD;
      end
   end

   // With the skid full, ready is low, so UNSKID never has to accept as well.
   always_comb begin
      main_v_d   = main_v_q;
      skid_v_d   = skid_v_q;
      main_dat_d = main_dat_q;
      skid_dat_d = skid_dat_q;
      unique case (op)
         SLOT_FLUSH: begin
            main_v_d   = 1'b0;
            skid_v_d   = 1'b0;
            main_dat_d = main_flush;
            skid_dat_d = skid_flush;
         end
         SLOT_UNSKID: begin
            main_v_d   = 1'b1;
            main_dat_d = skid_dat_q;
            skid_v_d   = 1'b0;
         end
         SLOT_LOAD: begin
            main_v_d = acc;
            if (acc) begin
               main_dat_d = in_data_i;
            end
         end
         SLOT_STALL: begin
            if (acc) begin
               skid_v_d   = 1'b1;
               skid_dat_d = in_data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_v_q   <= 1'b0;
         skid_v_q   <= 1'b0;
         main_dat_q <= BUBBLE_VAL;
         skid_dat_q <= BUBBLE_VAL;
      end else begin
         main_v_q   <= main_v_d;
         skid_v_q   <= skid_v_d;
         main_dat_q <= main_dat_d;
         skid_dat_q <= skid_dat_d;
      end
   end

   assign in_ready_o  = ~skid_v_q;
   assign out_valid_o = main_v_q;
   assign out_data_o  = main_dat_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Chain of DEPTH elastic slots between processor stages, with flush that
// squashes all entries and a registered count of entries held in the chain.
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int                DATA_W     = 16,
   parameter int                DEPTH      = 1,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
   parameter logic [DATA_W-1:0] KEEP_MASK  = '0,
   localparam int               OCC_W      = occ_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   // Index k is the input side of slot k; index DEPTH is the chain output.
   logic [DEPTH:0]             vld_chain;
   logic [DEPTH:0]             rdy_chain;
   logic [DEPTH:0][DATA_W-1:0] dat_chain;
   logic [OCC_W-1:0]           occ_q, occ_d;
   logic                       in_fire, out_fire;

   assign vld_chain[0]     = in_valid;
   assign dat_chain[0]     = in_data;
   assign in_ready         = rdy_chain[0];
   assign rdy_chain[DEPTH] = out_ready;
   assign out_valid        = vld_chain[DEPTH];
   assign out_data         = dat_chain[DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      elastic_slot #(
         .DATA_W     (DATA_W),
         .BUBBLE_VAL (BUBBLE_VAL),
         .KEEP_MASK  (KEEP_MASK)
      ) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .flush_i     (flush),
         .in_valid_i  (vld_chain[k]),
         .in_ready_o  (rdy_chain[k]),
         .in_data_i   (dat_chain[k]),
         .out_valid_o (vld_chain[k+1]),
         .out_ready_i (rdy_chain[k+1]),
         .out_data_o  (dat_chain[k+1])
      );
   end

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else begin
         occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: three instances (DEPTH 3, 1, 4) checked
// against a queue-per-instance reference model plus directed scenarios.
module tb_pipe_stage_elastic;

   localparam int NI = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush     [NI];
   logic        in_valid  [NI];
   logic        in_ready  [NI];
   logic [15:0] in_data   [NI];
   logic        out_valid [NI];
   logic        out_ready [NI];
   logic [15:0] out_data  [NI];
   logic [2:0]  occ_a;
   logic [1:0]  occ_b;
   logic [3:0]  occ_c;
   logic [3:0]  occ_all   [NI];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.DATA_W(16), .DEPTH(3), .BUBBLE_VAL(16'h0000), .KEEP_MASK(16'hC000)) u_d3 (
      .clk(clk), .rst_n(rst_n), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .occupancy(occ_a));

   pipe_stage_elastic #(.DATA_W(16), .DEPTH(1), .BUBBLE_VAL(16'h5A5A), .KEEP_MASK(16'h0000)) u_d1 (
      .clk(clk), .rst_n(rst_n), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .occupancy(occ_b));

   pipe_stage_elastic #(.DATA_W(16), .DEPTH(4), .BUBBLE_VAL(16'h1234), .KEEP_MASK(16'h00FF)) u_d4 (
      .clk(clk), .rst_n(rst_n), .flush(flush[2]),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
      .occupancy(occ_c));

   assign occ_all[0] = {1'b0, occ_a};
   assign occ_all[1] = {2'b00, occ_b};
   assign occ_all[2] = occ_c;

   function automatic int max_occ(input int i);
      case (i)
         0:       return 6;
         1:       return 2;
         default: return 8;
      endcase
   endfunction

   function automatic logic [15:0] bubble(input int i);
      case (i)
         0:       return 16'h0000;
         1:       return 16'h5A5A;
         default: return 16'h1234;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: one FIFO queue per instance, updated from the handshakes
   // seen just before each rising edge.
   logic [15:0] sb      [NI][$];
   logic        stalled [NI];
   logic [15:0] held    [NI];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            sb[i].delete();
            stalled[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            check($sformatf("occ%0d", i), 32'(occ_all[i]), 32'(sb[i].size()));
            check($sformatf("occ_max%0d", i), 32'(int'(occ_all[i]) <= max_occ(i)), 32'd1);
            check($sformatf("valid_empty%0d", i), 32'(out_valid[i] && sb[i].size() == 0), 32'd0);
            if (stalled[i]) begin
               check($sformatf("stall_valid%0d", i), 32'(out_valid[i]), 32'd1);
               check($sformatf("stall_data%0d", i), 32'(out_data[i]), 32'(held[i]));
            end
            if (flush[i]) begin
               sb[i].delete();
            end else begin
               if (out_valid[i] && out_ready[i] && sb[i].size() > 0)
                  check($sformatf("out_data%0d", i), 32'(out_data[i]), 32'(sb[i].pop_front()));
               if (in_valid[i] && in_ready[i])
                  sb[i].push_back(in_data[i]);
            end
            stalled[i] = out_valid[i] && !out_ready[i] && !flush[i];
            held[i]    = out_data[i];
         end
      end
   end

   task automatic push(input int i, input logic [15:0] d, output bit ok);
      ok          = 1'b0;
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      for (int c = 0; c < 40 && !ok; c++) begin
         ok = in_ready[i];
         tick();
      end
      in_valid[i] = 1'b0;
      if (!ok) check($sformatf("push_timeout%0d", i), 32'(ok), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ok, fire, seen;
      int          first_out, last_out, nout, drops, got, acc_n, n_acc;
      logic [15:0] outs [4];

      for (int i = 0; i < NI; i++) begin
         flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = '0;
      end
      #1 rst_n = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst_valid%0d", i), 32'(out_valid[i]), 32'd0);
         check($sformatf("rst_ready%0d", i), 32'(in_ready[i]), 32'd1);
         check($sformatf("rst_occ%0d", i), 32'(occ_all[i]), 32'd0);
         check($sformatf("rst_data%0d", i), 32'(out_data[i]), 32'(bubble(i)));
      end
      rst_n = 1'b1;
      tick();

      // Streaming 1..16 through DEPTH=3 with the sink always ready
      out_ready[0] = 1'b1;
      first_out = -1; last_out = -1; nout = 0; drops = 0;
      for (int c = 0; c < 24; c++) begin
         in_valid[0] = (c < 16);
         in_data[0]  = 16'(c + 1);
         if (c < 16 && !in_ready[0]) drops++;
         if (out_valid[0]) begin
            if (first_out < 0) first_out = c;
            last_out = c;
            nout++;
         end
         tick();
      end
      in_valid[0] = 1'b0;
      check("stream_latency", 32'(first_out), 32'd3);
      check("stream_count", 32'(nout), 32'd16);
      check("stream_last", 32'(last_out), 32'd18);
      check("stream_ready", 32'(drops), 32'd0);

      // Backpressure on DEPTH=1
      out_ready[1] = 1'b0;
      push(1, 16'hAAAA, ok);
      push(1, 16'hBBBB, ok);
      in_valid[1] = 1'b1;
      in_data[1]  = 16'hCCCC;
      check("bp_ready", 32'(in_ready[1]), 32'd0);
      check("bp_occ", 32'(occ_all[1]), 32'd2);
      check("bp_head", 32'(out_data[1]), 32'hAAAA);
      repeat (2) tick();
      check("bp_hold_ready", 32'(in_ready[1]), 32'd0);
      check("bp_hold_occ", 32'(occ_all[1]), 32'd2);
      out_ready[1] = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         fire = in_valid[1] && in_ready[1];
         if (out_valid[1]) begin
            if (got < 4) outs[got] = out_data[1];
            got++;
         end
         tick();
         if (fire) in_valid[1] = 1'b0;
      end
      check("bp_count", 32'(got), 32'd3);
      check("bp_out0", 32'(outs[0]), 32'hAAAA);
      check("bp_out1", 32'(outs[1]), 32'hBBBB);
      check("bp_out2", 32'(outs[2]), 32'hCCCC);

      // Bubble collapse on DEPTH=3: one entry stalled at the output
      out_ready[0] = 1'b0;
      push(0, 16'h0100, ok);
      for (int c = 0; c < 10 && !out_valid[0]; c++) tick();
      check("bc_head_valid", 32'(out_valid[0]), 32'd1);
      acc_n = 0;
      for (int c = 0; c < 20 && acc_n < 5; c++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 16'h0101 + 16'(acc_n);
         fire = in_ready[0];
         tick();
         if (fire) acc_n++;
      end
      in_valid[0] = 1'b0;
      check("bc_accepted", 32'(acc_n), 32'd5);
      check("bc_occ", 32'(occ_all[0]), 32'd6);
      check("bc_full_ready", 32'(in_ready[0]), 32'd0);
      out_ready[0] = 1'b1;
      for (int c = 0; c < 20 && occ_all[0] != 0; c++) tick();
      check("bc_drain", 32'(occ_all[0]), 32'd0);

      // Flush with KEEP_MASK=0xC000 while a new word is offered
      out_ready[0] = 1'b0;
      for (int k = 0; k < 6; k++) push(0, 16'hF123, ok);
      check("fl_pre_occ", 32'(occ_all[0]), 32'd6);
      flush[0]    = 1'b1;
      in_valid[0] = 1'b1;
      in_data[0]  = 16'h0BAD;
      tick();
      flush[0]    = 1'b0;
      in_valid[0] = 1'b0;
      check("fl_valid", 32'(out_valid[0]), 32'd0);
      check("fl_occ", 32'(occ_all[0]), 32'd0);
      check("fl_data", 32'(out_data[0]), 32'hC000);
      check("fl_ready", 32'(in_ready[0]), 32'd1);
      out_ready[0] = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         if (out_valid[0]) seen = 1'b1;
         tick();
      end
      check("fl_dropped", 32'(seen), 32'd0);

      // Asynchronous reset in the middle of traffic
      out_ready[0] = 1'b0; out_ready[1] = 1'b0;
      in_valid[0]  = 1'b1; in_data[0] = 16'h1111;
      in_valid[1]  = 1'b1; in_data[1] = 16'h2222;
      repeat (3) tick();
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      check("pre_rst_occ0", 32'(occ_all[0]), 32'd3);
      check("pre_rst_occ1", 32'(occ_all[1]), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("arst_valid%0d", i), 32'(out_valid[i]), 32'd0);
         check($sformatf("arst_ready%0d", i), 32'(in_ready[i]), 32'd1);
         check($sformatf("arst_occ%0d", i), 32'(occ_all[i]), 32'd0);
         check($sformatf("arst_data%0d", i), 32'(out_data[i]), 32'(bubble(i)));
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Random valid/ready traffic on DEPTH=4
      n_acc = 0;
      for (int c = 0; c < 10000; c++) begin
         in_valid[2]  = ($urandom_range(0, 3) != 0);
         in_data[2]   = 16'($urandom);
         out_ready[2] = ($urandom_range(0, 2) != 0);
         if (in_valid[2] && in_ready[2]) n_acc++;
         tick();
      end
      in_valid[2]  = 1'b0;
      out_ready[2] = 1'b1;
      for (int c = 0; c < 30 && occ_all[2] != 0; c++) tick();
      check("rnd_drain_occ", 32'(occ_all[2]), 32'd0);
      check("rnd_drain_model", 32'(sb[2].size()), 32'd0);
      check("rnd_activity", 32'(n_acc > 1000), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
